// File: rtl/delay_pipe_sched.sv
// ---------------------------------------------------------------------------
// delay_pipe_sched
//
// Round-robin scheduler that shares one fixed-latency delay pipe between R
// requesters. It grants at most one requester per cycle and registers the
// granted word into the pipe. A LAT+1 deep tag pipeline tracks who issued
// each word so the pipe output can be steered back to its owner. Each
// requester may have at most OUTS_MAX words in flight.
//
// Ports:
//   clk           clock
//   rst           synchronous active-high reset
//   req_vld       per-requester request valid (R bits)
//   req_dat       per-requester data, requester i at [i*W +: W]
//   req_rdy       one-hot grant (combinational from req_vld)
//   pipe_in       registered data to the pipe
//   pipe_in_vld   registered valid to the pipe
//   pipe_out      data returning from the pipe
//   pipe_out_vld  valid returning from the pipe
//   rsp_vld       one-hot response valid
//   rsp_dat       response data (pipe_out passed through)
//   err_r         sticky latency-mismatch flag
//
// Optional feature macro: DELAY_PIPE_SCHED_LAT_CHK_EN
//   Defined   -> pipe_out_vld is compared against the oldest tag valid every
//                cycle; any mismatch sets err_r until rst.
//   Undefined -> no checker, err_r tied to 0.
// ---------------------------------------------------------------------------
module delay_pipe_sched #(
    parameter int R        = 4,
    parameter int W        = 32,
    parameter int LAT      = 5,
    parameter int OUTS_MAX = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [R-1:0]   req_vld,
    input  logic [R*W-1:0] req_dat,
    output logic [R-1:0]   req_rdy,
    output logic [W-1:0]   pipe_in,
    output logic           pipe_in_vld,
    input  logic [W-1:0]   pipe_out,
    input  logic           pipe_out_vld,
    output logic [R-1:0]   rsp_vld,
    output logic [W-1:0]   rsp_dat,
    output logic           err_r
);

    localparam int IDW = (R > 1) ? $clog2(R) : 1;
    localparam int CW  = $clog2(OUTS_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(OUTS_MAX);

    logic [IDW-1:0]         lastGrant_q, lastGrant_d;
    logic [R-1:0][CW-1:0]   cnt_q, cnt_d;
    logic                   pipeInVld_q;
    logic [W-1:0]           pipeIn_q;
    logic [LAT:0]           tagVld_q;
    logic [LAT:0][IDW-1:0]  tagId_q;

    logic [R-1:0]           eligible;
    logic [R-1:0]           grantVec;
    logic                   grantAny;
    logic [IDW-1:0]         grantId;
    logic [IDW-1:0]         candId;
    logic [W-1:0]           grantDat;

    // A requester may be granted only while it is below its in-flight limit.
    // The registered count is used, so returned credit is usable next cycle.
    // Grants are suppressed while rst is high.
    always_comb begin
        for (int i = 0; i < R; i++) begin
            eligible[i] = !rst && req_vld[i] && (cnt_q[i] < CNT_MAX);
        end
    end

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        grantAny = 1'b0;
        grantId  = '0;
        candId   = '0;
        for (int k = 1; k <= R; k++) begin
            candId = IDW'((int'(lastGrant_q) + k) % R);
            if (!grantAny && eligible[candId]) begin
                grantAny = 1'b1;
                grantId  = candId;
            end
        end
        grantVec    = grantAny ? (R'(1) << grantId) : '0;
        lastGrant_d = grantAny ? grantId : lastGrant_q;
        grantDat    = req_dat[int'(grantId)*W +: W];
    end

    assign req_rdy = grantVec;

    // A response is routed only when the oldest tag is valid; a stray
    // pipe_out_vld against an empty tag slot is dropped.
    always_comb begin
        rsp_vld = '0;
        if (pipe_out_vld && tagVld_q[LAT]) begin
            rsp_vld = R'(1) << tagId_q[LAT];
        end
    end

    assign rsp_dat = pipe_out;

    // Per-requester in-flight counters. A grant and a response to the same
    // requester in one cycle cancel out; the guards keep counts from wrapping.
    always_comb begin
        for (int i = 0; i < R; i++) begin
            cnt_d[i] = cnt_q[i];
            if (grantVec[i] && !rsp_vld[i] && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end else if (!grantVec[i] && rsp_vld[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CW'(1);
            end
        end
    end

    // Control state: pointer, counts, issue valid and tag pipeline. The
    // pointer resets to R-1 so requester 0 is searched first.
    always_ff @(posedge clk) begin
        if (rst) begin
            lastGrant_q <= IDW'(R - 1);
            cnt_q       <= '0;
            pipeInVld_q <= 1'b0;
            tagVld_q    <= '0;
            tagId_q     <= '0;
        end else begin
            lastGrant_q <= lastGrant_d;
            cnt_q       <= cnt_d;
            pipeInVld_q <= grantAny;
            tagVld_q    <= {tagVld_q[LAT-1:0], grantAny};
            tagId_q     <= {tagId_q[LAT-1:0], grantId};
        end
    end

    // Issue data holds its last value when idle to avoid needless toggling.
    always_ff @(posedge clk) begin
        if (grantAny) begin
            pipeIn_q <= grantDat;
        end
    end

    assign pipe_in     = pipeIn_q;
    assign pipe_in_vld = pipeInVld_q;

`ifdef DELAY_PIPE_SCHED_LAT_CHK_EN
    logic err_q;

    // Sticky flag: the pipe's output valid must track the oldest tag valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (pipe_out_vld != tagVld_q[LAT]) begin
            err_q <= 1'b1;
        end
    end

    assign err_r = err_q;
`else
    assign err_r = 1'b0;
`endif

endmodule

// File: tb/tb_delay_pipe_sched.sv
// ---------------------------------------------------------------------------
// tb_delay_pipe_sched
//
// Self-checking bench for delay_pipe_sched (R=4, W=32, LAT=5, OUTS_MAX=2).
// An echo pipe model returns pipe_in after LAT cycles and shares rst.
// Inputs change 1 time unit after the rising edge, outputs are compared at
// the falling edge of the same cycle.
// ---------------------------------------------------------------------------
module tb_delay_pipe_sched;

    localparam int R        = 4;
    localparam int W        = 32;
    localparam int LAT      = 5;
    localparam int OUTS_MAX = 2;

`ifdef DELAY_PIPE_SCHED_LAT_CHK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic           clk;
    logic           rst;
    logic [R-1:0]   req_vld;
    logic [R*W-1:0] req_dat;
    logic [R-1:0]   req_rdy;
    logic [W-1:0]   pipe_in;
    logic           pipe_in_vld;
    logic [W-1:0]   pipe_out;
    logic           pipe_out_vld;
    logic [R-1:0]   rsp_vld;
    logic [W-1:0]   rsp_dat;
    logic           err_r;

    logic           forceVld;
    logic [LAT-1:0] pvS;
    logic [W-1:0]   pdS [LAT];

    int errors;
    int checks;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  rdy;
        logic        pv;
        logic        chkIn;
        logic [31:0] pin;
        logic [3:0]  rsp;
        logic [31:0] rdat;
    } vec_t;

    vec_t vecs[$];

    delay_pipe_sched #(
        .R(R), .W(W), .LAT(LAT), .OUTS_MAX(OUTS_MAX)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_vld      (req_vld),
        .req_dat      (req_dat),
        .req_rdy      (req_rdy),
        .pipe_in      (pipe_in),
        .pipe_in_vld  (pipe_in_vld),
        .pipe_out     (pipe_out),
        .pipe_out_vld (pipe_out_vld),
        .rsp_vld      (rsp_vld),
        .rsp_dat      (rsp_dat),
        .err_r        (err_r)
    );

    // Clock generation, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Echo pipe: pipe_in appears on pipe_out exactly LAT cycles later.
    always @(posedge clk) begin
        if (rst) begin
            pvS <= '0;
        end else begin
            pvS <= {pvS[LAT-2:0], pipe_in_vld};
            pdS[0] <= pipe_in;
            for (int s = 1; s < LAT; s++) begin
                pdS[s] <= pdS[s-1];
            end
        end
    end

    assign pipe_out_vld = pvS[LAT-1] | forceVld;
    assign pipe_out     = pdS[LAT-1];

    function automatic logic [31:0] datOf(input int i);
        case (i)
            0:       return 32'h0000_00A5;
            1:       return 32'h0000_00B1;
            2:       return 32'h0000_00C2;
            default: return 32'h0000_00D3;
        endcase
    endfunction

    // Safety net so the bench can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic addVec(input logic r, input logic [3:0] req, input logic [3:0] rdy,
                          input logic pv, input logic chkIn, input logic [31:0] pin,
                          input logic [3:0] rsp, input logic [31:0] rdat);
        vec_t v;
        v.rst = r; v.req = req; v.rdy = rdy; v.pv = pv;
        v.chkIn = chkIn; v.pin = pin; v.rsp = rsp; v.rdat = rdat;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs and move to the sampling point of that cycle.
    task automatic applyStimulus(input logic r, input logic [3:0] req, input logic fv);
        @(posedge clk);
        #1;
        rst      = r;
        req_vld  = req;
        forceVld = fv;
        #4;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] eRdy, input logic ePv,
                               input logic chkIn, input logic [31:0] ePin,
                               input logic [3:0] eRsp, input logic [31:0] eRdat,
                               input logic eErr);
        checks++;
        if (req_rdy !== eRdy) begin
            errors++;
            $display("[TB] FAIL %s req_rdy: got %b expected %b", name, req_rdy, eRdy);
        end
        checks++;
        if (pipe_in_vld !== ePv) begin
            errors++;
            $display("[TB] FAIL %s pipe_in_vld: got %b expected %b", name, pipe_in_vld, ePv);
        end
        if (chkIn) begin
            checks++;
            if (pipe_in !== ePin) begin
                errors++;
                $display("[TB] FAIL %s pipe_in: got %h expected %h", name, pipe_in, ePin);
            end
        end
        checks++;
        if (rsp_vld !== eRsp) begin
            errors++;
            $display("[TB] FAIL %s rsp_vld: got %b expected %b", name, rsp_vld, eRsp);
        end
        if (eRsp != 4'b0000) begin
            checks++;
            if (rsp_dat !== eRdat) begin
                errors++;
                $display("[TB] FAIL %s rsp_dat: got %h expected %h", name, rsp_dat, eRdat);
            end
        end
        checks++;
        if (err_r !== eErr) begin
            errors++;
            $display("[TB] FAIL %s err_r: got %b expected %b", name, err_r, eErr);
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        rst      = 1'b1;
        req_vld  = '0;
        forceVld = 1'b0;
        req_dat  = {datOf(3), datOf(2), datOf(1), datOf(0)};

        // Single request from requester 0.
        addVec(0, 4'b0001, 4'b0001, 0, 0, 32'h0,  4'b0000, 32'h0);
        addVec(0, 4'b0000, 4'b0000, 1, 1, 32'hA5, 4'b0000, 32'h0);
        for (int c = 2; c <= 5; c++)
            addVec(0, 4'b0000, 4'b0000, 0, 1, 32'hA5, 4'b0000, 32'h0);
        addVec(0, 4'b0000, 4'b0000, 0, 1, 32'hA5, 4'b0001, 32'hA5);
        addVec(0, 4'b0000, 4'b0000, 0, 1, 32'hA5, 4'b0000, 32'h0);
        addVec(1, 4'b0000, 4'b0000, 0, 0, 32'h0,  4'b0000, 32'h0);

        // All four requesting continuously: 0,1,2,3,... responses 6 later.
        for (int c = 0; c < 12; c++)
            addVec(0, 4'b1111, 4'(1 << (c % 4)), c >= 1, c >= 1, datOf((c + 3) % 4),
                   (c >= 6) ? 4'(1 << ((c + 2) % 4)) : 4'b0000, datOf((c + 2) % 4));
        addVec(1, 4'b0000, 4'b0000, 0, 0, 32'h0, 4'b0000, 32'h0);

        // Reset mid-flight: requester 0 at its limit and pointer on 0.
        addVec(0, 4'b0010, 4'b0010, 0, 0, 32'h0,  4'b0000, 32'h0);
        addVec(0, 4'b0001, 4'b0001, 1, 1, 32'hB1, 4'b0000, 32'h0);
        addVec(0, 4'b0001, 4'b0001, 1, 1, 32'hA5, 4'b0000, 32'h0);
        addVec(1, 4'b0000, 4'b0000, 0, 0, 32'h0,  4'b0000, 32'h0);
        addVec(0, 4'b0011, 4'b0001, 0, 0, 32'h0,  4'b0000, 32'h0);
        addVec(0, 4'b0011, 4'b0010, 1, 1, 32'hA5, 4'b0000, 32'h0);
        addVec(0, 4'b0000, 4'b0000, 1, 1, 32'hB1, 4'b0000, 32'h0);
        for (int c = 3; c <= 5; c++)
            addVec(0, 4'b0000, 4'b0000, 0, 1, 32'hB1, 4'b0000, 32'h0);
        addVec(0, 4'b0000, 4'b0000, 0, 1, 32'hB1, 4'b0001, 32'hA5);
        addVec(0, 4'b0000, 4'b0000, 0, 1, 32'hB1, 4'b0010, 32'hB1);
        addVec(0, 4'b0000, 4'b0000, 0, 1, 32'hB1, 4'b0000, 32'h0);
        addVec(1, 4'b0000, 4'b0000, 0, 0, 32'h0,  4'b0000, 32'h0);

        // Idle gaps: requests in cycles 0 and 3 only.
        addVec(0, 4'b0001, 4'b0001, 0, 0, 32'h0,  4'b0000, 32'h0);
        addVec(0, 4'b0000, 4'b0000, 1, 1, 32'hA5, 4'b0000, 32'h0);
        addVec(0, 4'b0000, 4'b0000, 0, 1, 32'hA5, 4'b0000, 32'h0);
        addVec(0, 4'b0010, 4'b0010, 0, 1, 32'hA5, 4'b0000, 32'h0);
        addVec(0, 4'b0000, 4'b0000, 1, 1, 32'hB1, 4'b0000, 32'h0);
        addVec(0, 4'b0000, 4'b0000, 0, 1, 32'hB1, 4'b0000, 32'h0);
        addVec(0, 4'b0000, 4'b0000, 0, 1, 32'hB1, 4'b0001, 32'hA5);
        addVec(0, 4'b0000, 4'b0000, 0, 1, 32'hB1, 4'b0000, 32'h0);
        addVec(0, 4'b0000, 4'b0000, 0, 1, 32'hB1, 4'b0000, 32'h0);
        addVec(0, 4'b0000, 4'b0000, 0, 1, 32'hB1, 4'b0010, 32'hB1);
        addVec(0, 4'b0000, 4'b0000, 0, 1, 32'hB1, 4'b0000, 32'h0);

        // Initial reset, then an idle cycle to check reset values.
        applyStimulus(1, 4'b0000, 0);
        applyStimulus(1, 4'b0000, 0);
        applyStimulus(0, 4'b0000, 0);
        checkOutput("reset", 4'b0000, 0, 0, 32'h0, 4'b0000, 32'h0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].req, 0);
            if (!vecs[i].rst)
                checkOutput($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].pv, vecs[i].chkIn,
                            vecs[i].pin, vecs[i].rsp, vecs[i].rdat, 0);
        end

        // Outstanding limit on requester 2, including a grant and a response
        // to the same requester in one cycle (cycles 7 and 14).
        applyStimulus(1, 4'b0000, 0);
        for (int c = 0; c <= 14; c++) begin
            logic [3:0] eRdy;
            logic [3:0] eRsp;
            logic       ePv;
            applyStimulus(0, 4'b0100, 0);
            eRdy = (c == 0 || c == 1 || c == 7 || c == 8 || c == 14) ? 4'b0100 : 4'b0000;
            eRsp = (c == 6 || c == 7 || c == 13 || c == 14) ? 4'b0100 : 4'b0000;
            ePv  = (c == 1 || c == 2 || c == 8 || c == 9);
            checkOutput($sformatf("limit_c%0d", c), eRdy, ePv, ePv, 32'hC2, eRsp, 32'hC2, 0);
        end

        // Stray pipe_out_vld with no matching tag.
        applyStimulus(1, 4'b0000, 0);
        for (int c = 0; c <= 7; c++) begin
            applyStimulus(0, 4'b0000, c == 4);
            checkOutput($sformatf("stray_c%0d", c), 4'b0000, 0, 0, 32'h0, 4'b0000, 32'h0,
                        (c >= 5) ? EXP_ERR : 1'b0);
        end
        applyStimulus(1, 4'b0000, 0);
        applyStimulus(0, 4'b0000, 0);
        checkOutput("stray_cleared", 4'b0000, 0, 0, 32'h0, 4'b0000, 32'h0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
